// File: rtl/vid_timing_measure.sv
// Passive frame-timing monitor on the native video output: per-frame active width/height,
// line period and pixel checksum, published once per frame with sticky consistency flags.
module vid_timing_measure #(
  parameter int CNT_W  = 12,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vid_active_video,
  input  logic              vid_hblank,
  input  logic              vid_vblank,
  input  logic              vid_hsync,
  input  logic              vid_vsync,
  input  logic [DATA_W-1:0] vid_data,
  input  logic              meas_clear,
  output logic [CNT_W-1:0]  meas_width,
  output logic [CNT_W-1:0]  meas_height,
  output logic [CNT_W-1:0]  meas_htotal,
  output logic [31:0]       meas_checksum,
  output logic [15:0]       frame_count,
  output logic              meas_valid,
  output logic              frame_done,
  output logic              err_width,
  output logic              err_height,
  output logic              err_protocol
);

  typedef enum logic {ARMED, MEASURE} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  // hblank and vsync are observed only; nothing in the measurement depends on them
  logic unused_mon;
  assign unused_mon = ^{vid_hblank, vid_vsync};

  state_e             state_q, state_d;
  logic               av_r1_q, vb_r1_q, hs_r1_q;
  logic               av_r2_q, vb_r2_q, hs_r2_q;
  logic [DATA_W-1:0]  data_r1_q;

  logic [CNT_W-1:0]   pix_q, pix_d;
  logic [CNT_W-1:0]   line_q, line_d;
  logic [CNT_W-1:0]   wlat_q, wlat_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [31:0]        acc_q, acc_d;

  logic [CNT_W-1:0]   width_q, width_d;
  logic [CNT_W-1:0]   height_q, height_d;
  logic [CNT_W-1:0]   htotal_q, htotal_d;
  logic [31:0]        csum_q, csum_d;
  logic [15:0]        fcnt_q, fcnt_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               errw_q, errw_d;
  logic               errh_q, errh_d;
  logic               errp_q, errp_d;

  logic               pix_ok, line_end, frame_end, hs_rise;
  logic [CNT_W-1:0]   line_v, wlat_v;

  assign pix_ok    = av_r1_q & ~vb_r1_q;
  // a line ends only after a counted pixel, so a stray pulse inside vblank is not a line
  assign line_end  = av_r2_q & ~av_r1_q & ~vb_r2_q;
  assign frame_end = vb_r1_q & ~vb_r2_q;
  assign hs_rise   = hs_r1_q & ~hs_r2_q;

  always_comb begin
    state_d  = state_q;
    pix_d    = pix_q;
    line_d   = line_q;
    wlat_d   = wlat_q;
    acc_d    = acc_q;
    width_d  = width_q;
    height_d = height_q;
    htotal_d = htotal_q;
    csum_d   = csum_q;
    fcnt_d   = fcnt_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    errw_d   = errw_q;
    errh_d   = errh_q;
    errp_d   = errp_q;
    line_v   = line_q;
    wlat_v   = wlat_q;

    if (av_r1_q && vb_r1_q) errp_d = 1'b1;

    // counter restarts at 1 so the captured value is the full period in clocks
    if (hs_rise) begin
      htotal_d = hcnt_q;
      hcnt_d   = ONE;
    end else begin
      hcnt_d   = sat_inc(hcnt_q);
    end

    case (state_q)
      ARMED: begin
        if (frame_end) state_d = MEASURE;
      end
      MEASURE: begin
        if (pix_ok) begin
          pix_d = sat_inc(pix_q);
          acc_d = acc_q + 32'(data_r1_q);
        end
        // line end is folded in before the frame-end publish below
        if (line_end) begin
          line_v = sat_inc(line_q);
          pix_d  = '0;
          if (line_q == '0)        wlat_v = pix_q;
          else if (pix_q != wlat_q) errw_d = 1'b1;
        end
        line_d = line_v;
        wlat_d = wlat_v;
        if (frame_end) begin
          if (line_v != '0) begin
            width_d  = wlat_v;
            height_d = line_v;
            csum_d   = acc_q;
            fcnt_d   = fcnt_q + 16'd1;
            valid_d  = 1'b1;
            done_d   = 1'b1;
            if (valid_q && (line_v != height_q)) errh_d = 1'b1;
          end
          line_d = '0;
          wlat_d = '0;
          acc_d  = '0;
          pix_d  = '0;
        end
      end
      default: state_d = ARMED;
    endcase

    if (meas_clear) begin
      state_d  = ARMED;
      pix_d    = '0;
      line_d   = '0;
      wlat_d   = '0;
      acc_d    = '0;
      width_d  = '0;
      height_d = '0;
      htotal_d = '0;
      csum_d   = '0;
      fcnt_d   = '0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      errw_d   = 1'b0;
      errh_d   = 1'b0;
      errp_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ARMED;
      av_r1_q   <= 1'b0;
      vb_r1_q   <= 1'b0;
      hs_r1_q   <= 1'b0;
      av_r2_q   <= 1'b0;
      vb_r2_q   <= 1'b0;
      hs_r2_q   <= 1'b0;
      data_r1_q <= '0;
      pix_q     <= '0;
      line_q    <= '0;
      wlat_q    <= '0;
      hcnt_q    <= '0;
      acc_q     <= '0;
      width_q   <= '0;
      height_q  <= '0;
      htotal_q  <= '0;
      csum_q    <= '0;
      fcnt_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      errw_q    <= 1'b0;
      errh_q    <= 1'b0;
      errp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      av_r1_q   <= vid_active_video;
      vb_r1_q   <= vid_vblank;
      hs_r1_q   <= vid_hsync;
      av_r2_q   <= av_r1_q;
      vb_r2_q   <= vb_r1_q;
      hs_r2_q   <= hs_r1_q;
      data_r1_q <= vid_data;
      pix_q     <= pix_d;
      line_q    <= line_d;
      wlat_q    <= wlat_d;
      hcnt_q    <= hcnt_d;
      acc_q     <= acc_d;
      width_q   <= width_d;
      height_q  <= height_d;
      htotal_q  <= htotal_d;
      csum_q    <= csum_d;
      fcnt_q    <= fcnt_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      errw_q    <= errw_d;
      errh_q    <= errh_d;
      errp_q    <= errp_d;
    end
  end

  assign meas_width    = width_q;
  assign meas_height   = height_q;
  assign meas_htotal   = htotal_q;
  assign meas_checksum = csum_q;
  assign frame_count   = fcnt_q;
  assign meas_valid    = valid_q;
  assign frame_done    = done_q;
  assign err_width     = errw_q;
  assign err_height    = errh_q;
  assign err_protocol  = errp_q;

endmodule
